// File: rtl/barrier_ctrl.sv
// barrier_ctrl: warp barrier controller for one core.
// Tracks the warps waiting on each barrier ID and releases them together once the
// expected count has arrived. Produces the scheduler's barrier stall mask and a
// one-cycle release pulse. Killed warps are removed from every barrier.
// Optional watchdog: define BARRIER_TIMEOUT_EN to build per-barrier wait counters
// that force a release after TIMEOUT_CYCLES cycles without an arrival.
module barrier_ctrl #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_BARRIERS   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  output logic                 bar_ready,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  input  logic                 kill_valid,
  input  logic [NW_BITS-1:0]   kill_wid,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 release_valid,
  output logic [NB_BITS-1:0]   release_id,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 err_dup,
  output logic                 err_size,
  output logic                 err_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("barrier_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  // Number of set bits in a warp mask.
  function automatic int popcount(input logic [NUM_WARPS-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (m[i]) c++;
    end
    return c;
  endfunction

  // Per-barrier state
  logic [NUM_WARPS-1:0]    mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    mask_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]      size_q [NUM_BARRIERS];
  logic [NW_BITS-1:0]      size_d [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] busy_q, busy_d;

  // Output registers
  logic                    rel_vld_q, rel_vld_d;
  logic [NB_BITS-1:0]      rel_id_q, rel_id_d;
  logic [NUM_WARPS-1:0]    rel_mask_q, rel_mask_d;
  logic [NUM_WARPS-1:0]    stall_q, stall_d;
  logic                    err_dup_q, err_dup_d;
  logic                    err_size_q, err_size_d;

  // Combinational helpers
  logic [NUM_WARPS-1:0]    kill_bit;
  logic [NUM_WARPS-1:0]    arr_bit;
  logic                    accept;
  logic                    arrive;
  logic [NUM_BARRIERS-1:0] hit_vec;
  logic [NW_BITS-1:0]      sz_w;
  logic                    comp_vld;
  logic [NB_BITS-1:0]      comp_id;
  logic [NUM_WARPS-1:0]    comp_mask;

`ifdef BARRIER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]        cnt_q [NUM_BARRIERS];
  logic [CNT_W-1:0]        cnt_d [NUM_BARRIERS];
  logic                    pend_vld_q, pend_vld_d;
  logic [NB_BITS-1:0]      pend_id_q, pend_id_d;
  logic [NUM_WARPS-1:0]    pend_mask_q, pend_mask_d;
  logic                    err_to_q, err_to_d;
  logic                    to_vld;
  logic [NB_BITS-1:0]      to_id;
  logic [NUM_WARPS-1:0]    to_mask;

  // A held completion also blocks new arrivals until it has been emitted.
  assign bar_ready   = !rel_vld_q && !pend_vld_q;
  assign err_timeout = err_to_q;
`else
  // The cycle after a release is a bubble so consecutive barriers stay ordered.
  assign bar_ready   = !rel_vld_q;
  assign err_timeout = 1'b0;
`endif

  assign stall_mask    = stall_q;
  assign release_valid = rel_vld_q;
  assign release_id    = rel_id_q;
  assign release_mask  = rel_mask_q;
  assign err_dup       = err_dup_q;
  assign err_size      = err_size_q;

  // Next-state: apply kill, then the arrival against the post-kill masks, then the watchdog.
  always_comb begin
    kill_bit   = '0;
    arr_bit    = '0;
    hit_vec    = '0;
    sz_w       = '0;
    comp_vld   = 1'b0;
    comp_id    = bar_id;
    comp_mask  = '0;
    err_dup_d  = err_dup_q;
    err_size_d = err_size_q;
    busy_d     = busy_q;

    for (int w = 0; w < NUM_WARPS; w++) begin
      if (kill_valid && (kill_wid == NW_BITS'(w))) kill_bit[w] = 1'b1;
      if (bar_wid == NW_BITS'(w)) arr_bit[w] = 1'b1;
    end

    accept = bar_valid && bar_ready;
    // A warp killed in the same cycle it arrives never joins the barrier.
    arrive = accept && !(kill_valid && (kill_wid == bar_wid));

    // Kill removes the warp everywhere; an emptied barrier goes idle.
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      mask_d[b] = mask_q[b] & ~kill_bit;
      size_d[b] = size_q[b];
      busy_d[b] = busy_q[b] && (mask_d[b] != '0);
      hit_vec[b] = arrive && (bar_id == NB_BITS'(b));
    end

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (hit_vec[b]) begin
        sz_w = size_q[b];
        if (!busy_d[b]) begin
          size_d[b] = bar_size_m1;
          sz_w      = bar_size_m1;
          busy_d[b] = 1'b1;
        end else if (bar_size_m1 != size_q[b]) begin
          err_size_d = 1'b1;
        end

        if ((mask_d[b] & arr_bit) != '0) begin
          err_dup_d = 1'b1;
        end else if ((popcount(mask_d[b] | arr_bit) - 1) == int'(sz_w)) begin
          comp_vld  = 1'b1;
          comp_mask = mask_d[b] | arr_bit;
          mask_d[b] = '0;
          busy_d[b] = 1'b0;
        end else begin
          mask_d[b] = mask_d[b] | arr_bit;
        end
      end
    end

`ifdef BARRIER_TIMEOUT_EN
    to_vld      = 1'b0;
    to_id       = '0;
    to_mask     = '0;
    pend_vld_d  = pend_vld_q;
    pend_id_d   = pend_id_q;
    pend_mask_d = pend_mask_q;

    // Counters run while busy and restart on arrival; the lowest expired ID fires,
    // others saturate at the limit and fire on later cycles.
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (!busy_d[b] || hit_vec[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] < CNT_LIMIT) begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end else begin
        cnt_d[b] = cnt_q[b];
      end

      if (!to_vld && busy_d[b] && !hit_vec[b] && (cnt_q[b] >= CNT_LIMIT)) begin
        to_vld    = 1'b1;
        to_id     = NB_BITS'(b);
        to_mask   = mask_d[b];
        mask_d[b] = '0;
        busy_d[b] = 1'b0;
        cnt_d[b]  = '0;
      end
    end

    err_to_d = err_to_q | to_vld;

    // Forced release wins the output; a simultaneous completion is parked one cycle.
    if (to_vld) begin
      rel_vld_d  = 1'b1;
      rel_id_d   = to_id;
      rel_mask_d = to_mask;
      if (comp_vld) begin
        pend_vld_d  = 1'b1;
        pend_id_d   = comp_id;
        pend_mask_d = comp_mask;
      end
    end else if (pend_vld_q) begin
      rel_vld_d  = 1'b1;
      rel_id_d   = pend_id_q;
      rel_mask_d = pend_mask_q;
      pend_vld_d = 1'b0;
    end else begin
      rel_vld_d  = comp_vld;
      rel_id_d   = comp_vld ? comp_id : '0;
      rel_mask_d = comp_mask;
    end
`else
    rel_vld_d  = comp_vld;
    rel_id_d   = comp_vld ? comp_id : '0;
    rel_mask_d = comp_mask;
`endif

    stall_d = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stall_d = stall_d | mask_d[b];
    end
  end

  // Control, mask and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= '0;
      end
      busy_q     <= '0;
      rel_vld_q  <= 1'b0;
      rel_id_q   <= '0;
      rel_mask_q <= '0;
      stall_q    <= '0;
      err_dup_q  <= 1'b0;
      err_size_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= mask_d[b];
      end
      busy_q     <= busy_d;
      rel_vld_q  <= rel_vld_d;
      rel_id_q   <= rel_id_d;
      rel_mask_q <= rel_mask_d;
      stall_q    <= stall_d;
      err_dup_q  <= err_dup_d;
      err_size_q <= err_size_d;
    end
  end

  // Latched barrier sizes are only read while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      size_q[b] <= size_d[b];
    end
  end

`ifdef BARRIER_TIMEOUT_EN
  // Watchdog counters and the parked completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        cnt_q[b] <= '0;
      end
      pend_vld_q  <= 1'b0;
      pend_id_q   <= '0;
      pend_mask_q <= '0;
      err_to_q    <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      pend_vld_q  <= pend_vld_d;
      pend_id_q   <= pend_id_d;
      pend_mask_q <= pend_mask_d;
      err_to_q    <= err_to_d;
    end
  end
`endif

endmodule

// File: tb/tb_barrier_ctrl.sv
// Testbench for barrier_ctrl: directed scenarios plus randomized traffic checked
// against a set-based reference model of the barrier rules.
module tb_barrier_ctrl;
  localparam int NW = 4;
  localparam int NB = 4;
`ifdef BARRIER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 65535;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       bar_valid;
  logic       bar_ready;
  logic [1:0] bar_wid, bar_id, bar_size_m1;
  logic       kill_valid;
  logic [1:0] kill_wid;
  logic [3:0] stall_mask;
  logic       release_valid;
  logic [1:0] release_id;
  logic [3:0] release_mask;
  logic       err_dup, err_size, err_timeout;

  always #5 clk = ~clk;

  barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .bar_valid(bar_valid), .bar_ready(bar_ready), .bar_wid(bar_wid), .bar_id(bar_id),
    .bar_size_m1(bar_size_m1), .kill_valid(kill_valid), .kill_wid(kill_wid),
    .stall_mask(stall_mask), .release_valid(release_valid), .release_id(release_id),
    .release_mask(release_mask), .err_dup(err_dup), .err_size(err_size),
    .err_timeout(err_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who waits where, the agreed group size, expected outputs.
  bit         m_wait [NB][NW];
  int         m_size [NB];
  bit         e_rv, e_dup, e_size, e_ready;
  int         e_rid;
  logic [3:0] e_rmask, e_stall;

  function automatic int waiters(int b);
    int c = 0;
    for (int w = 0; w < NW; w++) c += int'(m_wait[b][w]);
    return c;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      for (int w = 0; w < NW; w++) m_wait[b][w] = 1'b0;
      m_size[b] = 0;
    end
    e_rv = 0; e_rid = 0; e_rmask = '0; e_stall = '0;
    e_dup = 0; e_size = 0; e_ready = 1;
  endtask

  task automatic model_edge(bit bv, int wid, int id, int sz, bit kv, int kw);
    bit acc;
    int n;
    acc = bv && e_ready;
    e_rv = 0; e_rid = 0; e_rmask = '0;
    if (kv) for (int b = 0; b < NB; b++) m_wait[b][kw] = 1'b0;
    if (acc && !(kv && kw == wid)) begin
      n = waiters(id);
      if (n == 0) m_size[id] = sz;
      else if (sz != m_size[id]) e_size = 1;
      if (m_wait[id][wid]) begin
        e_dup = 1;
      end else if (n + 1 == m_size[id] + 1) begin
        e_rv = 1; e_rid = id;
        for (int w = 0; w < NW; w++) e_rmask[w] = m_wait[id][w];
        e_rmask[wid] = 1'b1;
        for (int w = 0; w < NW; w++) m_wait[id][w] = 1'b0;
      end else begin
        m_wait[id][wid] = 1'b1;
      end
    end
    e_stall = '0;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        if (m_wait[b][w]) e_stall[w] = 1'b1;
    e_ready = !e_rv;
  endtask

  // One clock of stimulus; outputs are then sampled 1 time unit after the edge.
  task automatic drive(bit bv, int wid, int id, int sz, bit kv, int kw);
    bar_valid = bv; bar_wid = 2'(wid); bar_id = 2'(id); bar_size_m1 = 2'(sz);
    kill_valid = kv; kill_wid = 2'(kw);
    model_edge(bv, wid, id, sz, kv, kw);
    @(posedge clk); #1;
    bar_valid = 1'b0; kill_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; bar_valid = 1'b0; kill_valid = 1'b0;
    bar_wid = '0; bar_id = '0; bar_size_m1 = '0; kill_wid = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (stall_mask !== 4'b0000) begin errors++; $display("FAIL reset_stall got=%b exp=0000", stall_mask); end
    checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b exp=0", release_valid); end
    checks++; if (bar_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bar_ready); end
    checks++; if ({err_dup, err_size, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_err got=%b exp=000", {err_dup, err_size, err_timeout}); end
  endtask

  task automatic test_basic();
    apply_reset();
    drive(1, 0, 1, 2, 0, 0);
    checks++; if (stall_mask !== 4'b0001) begin errors++; $display("FAIL basic_stall0 got=%b exp=0001", stall_mask); end
    drive(1, 1, 1, 2, 0, 0);
    checks++; if (stall_mask !== 4'b0011) begin errors++; $display("FAIL basic_stall1 got=%b exp=0011", stall_mask); end
    checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL basic_early_rv got=%b exp=0", release_valid); end
    drive(1, 2, 1, 2, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_id !== 2'd1 || release_mask !== 4'b0111) begin errors++; $display("FAIL basic_release got=%b/%0d/%b exp=1/1/0111", release_valid, release_id, release_mask); end
    checks++; if (stall_mask !== 4'b0000) begin errors++; $display("FAIL basic_stall2 got=%b exp=0000", stall_mask); end
    checks++; if (bar_ready !== 1'b0) begin errors++; $display("FAIL basic_bubble got=%b exp=0", bar_ready); end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (release_valid !== 1'b0 || bar_ready !== 1'b1) begin errors++; $display("FAIL basic_after got=%b/%b exp=0/1", release_valid, bar_ready); end
  endtask

  task automatic test_size_zero();
    apply_reset();
    drive(1, 3, 0, 0, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_id !== 2'd0 || release_mask !== 4'b1000) begin errors++; $display("FAIL sz0_release got=%b/%0d/%b exp=1/0/1000", release_valid, release_id, release_mask); end
    checks++; if (stall_mask !== 4'b0000) begin errors++; $display("FAIL sz0_stall got=%b exp=0000", stall_mask); end
  endtask

  task automatic test_kill();
    apply_reset();
    drive(1, 0, 2, 3, 0, 0);
    drive(1, 1, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (stall_mask !== 4'b0001 || release_valid !== 1'b0) begin errors++; $display("FAIL kill_one got=%b/%b exp=0001/0", stall_mask, release_valid); end
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (stall_mask !== 4'b0000 || release_valid !== 1'b0) begin errors++; $display("FAIL kill_all got=%b/%b exp=0000/0", stall_mask, release_valid); end
    drive(1, 2, 2, 1, 0, 0);
    checks++; if (stall_mask !== 4'b0100 || err_size !== 1'b0) begin errors++; $display("FAIL kill_relatch got=%b/%b exp=0100/0", stall_mask, err_size); end
    drive(1, 3, 2, 1, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_id !== 2'd2 || release_mask !== 4'b1100) begin errors++; $display("FAIL kill_newsize got=%b/%0d/%b exp=1/2/1100", release_valid, release_id, release_mask); end
  endtask

  task automatic test_dup_size();
    apply_reset();
    drive(1, 1, 0, 2, 0, 0);
    drive(1, 1, 0, 2, 0, 0);
    checks++; if (err_dup !== 1'b1 || stall_mask !== 4'b0010) begin errors++; $display("FAIL dup got=%b/%b exp=1/0010", err_dup, stall_mask); end
    checks++; if (err_size !== 1'b0) begin errors++; $display("FAIL dup_nosize got=%b exp=0", err_size); end
    drive(1, 2, 0, 1, 0, 0);
    checks++; if (err_size !== 1'b1 || stall_mask !== 4'b0110 || release_valid !== 1'b0) begin errors++; $display("FAIL size_err got=%b/%b/%b exp=1/0110/0", err_size, stall_mask, release_valid); end
  endtask

  task automatic test_kill_post();
    apply_reset();
    drive(1, 0, 3, 2, 0, 0);
    drive(1, 1, 3, 2, 0, 0);
    drive(1, 2, 3, 2, 1, 0);
    checks++; if (release_valid !== 1'b0 || stall_mask !== 4'b0110 || bar_ready !== 1'b1) begin errors++; $display("FAIL postkill got=%b/%b/%b exp=0/0110/1", release_valid, stall_mask, bar_ready); end
    drive(1, 3, 3, 2, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_id !== 2'd3 || release_mask !== 4'b1110) begin errors++; $display("FAIL postkill_rel got=%b/%0d/%b exp=1/3/1110", release_valid, release_id, release_mask); end
    checks++; if (bar_ready !== 1'b0) begin errors++; $display("FAIL postkill_ready got=%b exp=0", bar_ready); end
  endtask

  task automatic test_kill_same();
    apply_reset();
    drive(1, 1, 0, 1, 0, 0);
    drive(1, 2, 0, 1, 1, 2);
    checks++; if (stall_mask !== 4'b0010 || release_valid !== 1'b0 || bar_ready !== 1'b1) begin errors++; $display("FAIL killsame got=%b/%b/%b exp=0010/0/1", stall_mask, release_valid, bar_ready); end
    drive(1, 2, 0, 1, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_mask !== 4'b0110) begin errors++; $display("FAIL killsame_rel got=%b/%b exp=1/0110", release_valid, release_mask); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive(1, 0, 1, 0, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_mask !== 4'b0001 || bar_ready !== 1'b0) begin errors++; $display("FAIL b2b_first got=%b/%b/%b exp=1/0001/0", release_valid, release_mask, bar_ready); end
    drive(1, 1, 2, 0, 0, 0);
    checks++; if (release_valid !== 1'b0 || stall_mask !== 4'b0000) begin errors++; $display("FAIL b2b_bubble got=%b/%b exp=0/0000", release_valid, stall_mask); end
    drive(1, 1, 2, 0, 0, 0);
    checks++; if (release_valid !== 1'b1 || release_id !== 2'd2 || release_mask !== 4'b0010) begin errors++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/2/0010", release_valid, release_id, release_mask); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive(1, 0, 0, 2, 0, 0);
    drive(1, 1, 0, 2, 0, 0);
    reset = 1'b1; bar_valid = 1'b1; bar_wid = 2'd2; bar_id = 2'd0; bar_size_m1 = 2'd2;
    @(posedge clk); #1;
    checks++; if (release_valid !== 1'b0 || stall_mask !== 4'b0000) begin errors++; $display("FAIL midreset got=%b/%b exp=0/0000", release_valid, stall_mask); end
    bar_valid = 1'b0; reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (release_valid !== 1'b0 || bar_ready !== 1'b1) begin errors++; $display("FAIL midreset_after got=%b/%b exp=0/1", release_valid, bar_ready); end
  endtask

  task automatic test_random();
    int pref [NB];
    int wid, id, sz, kw;
    bit bv, kv;
    apply_reset();
    for (int b = 0; b < NB; b++) pref[b] = $urandom_range(0, 3);
    for (int i = 0; i < 400; i++) begin
      bv  = ($urandom_range(0, 3) != 0);
      wid = $urandom_range(0, 3);
      id  = $urandom_range(0, 3);
      sz  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : pref[id];
      kv  = ($urandom_range(0, 9) == 0);
      kw  = $urandom_range(0, 3);
      drive(bv, wid, id, sz, kv, kw);
      checks++; if (stall_mask !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall_mask, e_stall); end
      checks++; if (release_valid !== e_rv) begin errors++; $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", i, release_valid, e_rv); end
      checks++; if (bar_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bar_ready, e_ready); end
      checks++; if (err_dup !== e_dup || err_size !== e_size) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b%b exp=%b%b", i, err_dup, err_size, e_dup, e_size); end
      if (e_rv) begin
        checks++; if (release_id !== 2'(e_rid) || release_mask !== e_rmask) begin errors++; $display("FAIL rnd_rel cyc=%0d got=%0d/%b exp=%0d/%b", i, release_id, release_mask, e_rid, e_rmask); end
      end
    end
  endtask

`ifdef BARRIER_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    drive(1, 0, 1, 1, 0, 0);
    checks++; if (stall_mask !== 4'b0001 || err_timeout !== 1'b0) begin errors++; $display("FAIL to_wait got=%b/%b exp=0001/0", stall_mask, err_timeout); end
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (k < 8) begin
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL to_early k=%0d got=%b exp=0", k, release_valid); end
      end
    end
    checks++; if (release_valid !== 1'b1 || release_id !== 2'd1 || release_mask !== 4'b0001) begin errors++; $display("FAIL to_release got=%b/%0d/%b exp=1/1/0001", release_valid, release_id, release_mask); end
    checks++; if (err_timeout !== 1'b1 || stall_mask !== 4'b0000) begin errors++; $display("FAIL to_flag got=%b/%b exp=1/0000", err_timeout, stall_mask); end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_size_zero();
    test_kill();
    test_dup_size();
    test_kill_post();
    test_kill_same();
    test_back_to_back();
    test_mid_reset();
`ifdef BARRIER_TIMEOUT_EN
    test_timeout();
`else
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
